// File: rtl/datapath_pkg.sv
// Shared definitions for the Goldschmidt division datapath.
//   WIDTH    : operand/register width (Q1.15 format)
//   FRAC     : number of fraction bits
//   sel_nd_e : encodings of the multiplier B-operand select
package datapath_pkg;

  localparam int WIDTH = 16;
  localparam int FRAC  = 15;

  typedef enum logic [1:0] {
    SEL_D    = 2'b00,
    SEL_N    = 2'b01,
    SEL_REGD = 2'b10,
    SEL_REGN = 2'b11
  } sel_nd_e;

endpackage : datapath_pkg

// File: rtl/mul_q115.sv
// Unsigned WIDTH x WIDTH -> 2*WIDTH array multiplier.
// Built as a chain of shifted partial-product adders rather than '*',
// so the structure is explicit and independent of synthesis inference.
// Ports:
//   a [WIDTH-1:0]   multiplicand
//   b [WIDTH-1:0]   multiplier
//   p [2*WIDTH-1:0] full-width product a*b
module mul_q115 #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] p
);

  // Running sum after each row of the array; row i adds a*b[i] shifted by i.
  logic [2*WIDTH-1:0] row_sum [WIDTH+1];

  assign row_sum[0] = '0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_row
    logic [2*WIDTH-1:0] pp;
    assign pp             = {{WIDTH{1'b0}}, a & {WIDTH{b[i]}}} << i;
    assign row_sum[i + 1] = row_sum[i] + pp;
  end

  assign p = row_sum[WIDTH];

endmodule : mul_q115

// File: rtl/datapath.sv
// Goldschmidt-division iteration datapath, unsigned Q1.15 operands.
// One shared multiplier with operand muxes feeds three registers (N, D, K);
// an external controller sequences the iteration through the select/load
// strobes. The quotient converges in the N register, which drives result.
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-low reset; clears N, D and K
//   sel_K_mux   multiplier A operand: 1 = IA, 0 = regK
//   load_regN   capture truncated product into regN (regK <= 2 - old regD)
//   load_regD   capture truncated product into regD
//   sel_ND_mux  multiplier B operand: D / N / regD / regN
//   N, D, IA    dividend, normalised divisor, initial reciprocal estimate
//   result      current regN
module datapath #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sel_K_mux,
  input  logic             load_regN,
  input  logic             load_regD,
  input  logic [1:0]       sel_ND_mux,
  input  logic [WIDTH-1:0] N,
  input  logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] IA,
  output logic [WIDTH-1:0] result
);

  import datapath_pkg::*;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0]   reg_n, reg_d, reg_k;
  logic [WIDTH-1:0]   op_a, op_b;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   prod_q;
  logic               unused_prod_bits;
  sel_nd_e            sel_nd;

  assign sel_nd = sel_nd_e'(sel_ND_mux);
  assign op_a   = sel_K_mux ? IA : reg_k;

  // NOTE: every signal written in always_comb gets a default first so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    op_b = D;
    unique case (sel_nd)
      SEL_D:    op_b = D;
      SEL_N:    op_b = N;
      SEL_REGD: op_b = reg_d;
      SEL_REGN: op_b = reg_n;
      default:  op_b = D;
    endcase
  end

  mul_q115 #(.WIDTH(WIDTH)) u_mul (
    .a (op_a),
    .b (op_b),
    .p (prod)
  );

  // Q2.30 -> Q1.15 by truncation: the top integer bit never sets in the
  // operating range and the low fraction bits are simply dropped.
  assign prod_q           = prod[FRAC+WIDTH-1:FRAC];
  assign unused_prod_bits = ^{prod[2*WIDTH-1:FRAC+WIDTH], prod[FRAC-1:0]};

  // NOTE: sequential state uses non-blocking assignments so the K update
  // below sees the regD value from before this edge, as intended.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reg_n <= '0;
      reg_d <= '0;
      reg_k <= '0;
    end else begin
      if (load_regD) reg_d <= prod_q;
      if (load_regN) begin
        reg_n <= prod_q;
        // 2.0 - regD in Q1.15 is the two's complement; 2 - 0 wraps to 0.
        reg_k <= ~reg_d + ONE;
      end
    end
  end

  assign result = reg_n;

endmodule : datapath

// File: tb/tb_datapath.sv
// Self-checking bench for datapath: directed schedule table, hand-written
// corner sequences, and randomised steps against an arithmetic model.
module tb_datapath;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel_K_mux;
  logic        load_regN;
  logic        load_regD;
  logic [1:0]  sel_ND_mux;
  logic [15:0] N, D, IA;
  logic [15:0] result;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  datapath dut (
    .clk        (clk),
    .reset      (reset),
    .sel_K_mux  (sel_K_mux),
    .load_regN  (load_regN),
    .load_regD  (load_regD),
    .sel_ND_mux (sel_ND_mux),
    .N          (N),
    .D          (D),
    .IA         (IA),
    .result     (result)
  );

  typedef struct {
    logic        sel_k;
    logic [1:0]  sel_nd;
    logic        ld_d;
    logic        ld_n;
    logic [15:0] exp_n;
    logic [15:0] exp_d;
    logic [15:0] exp_k;
  } vec_t;

  task automatic check(input string name, input logic [15:0] actual,
                       input logic [15:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [15:0] en,
                           input logic [15:0] ed, input logic [15:0] ek);
    check({tag, " result"}, result, en);
    check({tag, " regD"}, dut.reg_d, ed);
    check({tag, " regK"}, dut.reg_k, ek);
  endtask

  // Apply one set of controls, let one rising edge pass, then settle.
  task automatic step(input logic sk, input logic [1:0] snd, input logic ld_d,
                      input logic ld_n, input logic [15:0] n_v,
                      input logic [15:0] d_v, input logic [15:0] ia_v);
    sel_K_mux  = sk;
    sel_ND_mux = snd;
    load_regD  = ld_d;
    load_regN  = ld_n;
    N          = n_v;
    D          = d_v;
    IA         = ia_v;
    @(posedge clk);
    #1;
  endtask

  // Reference model: Q1.15 values held as plain integers.
  int unsigned m_n, m_d, m_k;

  function automatic int unsigned q_mul(input int unsigned a, input int unsigned b);
    longint unsigned full;
    full = longint'(a) * longint'(b);
    return int'((full >> 15) % 65536);
  endfunction

  vec_t sched [8];

  initial begin
    // Standard schedule, IA = 1.0, D = 1.5, N = 1.0; quotient heads to 2/3.
    sched[0] = '{1'b1, 2'b00, 1'b1, 1'b0, 16'h0000, 16'hC000, 16'h0000};
    sched[1] = '{1'b1, 2'b01, 1'b0, 1'b1, 16'h8000, 16'hC000, 16'h4000};
    sched[2] = '{1'b0, 2'b10, 1'b1, 1'b0, 16'h8000, 16'h6000, 16'h4000};
    sched[3] = '{1'b0, 2'b11, 1'b0, 1'b1, 16'h4000, 16'h6000, 16'hA000};
    sched[4] = '{1'b0, 2'b10, 1'b1, 1'b0, 16'h4000, 16'h7800, 16'hA000};
    sched[5] = '{1'b0, 2'b11, 1'b0, 1'b1, 16'h5000, 16'h7800, 16'h8800};
    sched[6] = '{1'b0, 2'b10, 1'b1, 1'b0, 16'h5000, 16'h7F80, 16'h8800};
    sched[7] = '{1'b0, 2'b11, 1'b0, 1'b1, 16'h5500, 16'h7F80, 16'h8080};

    reset = 1'b0;
    sel_K_mux = 1'b0; sel_ND_mux = 2'b00; load_regD = 1'b0; load_regN = 1'b0;
    N = '0; D = '0; IA = '0;
    #1;
    check_all("power-on reset", 16'h0000, 16'h0000, 16'h0000);

    // Load arbitrary values, then reset asynchronously mid-cycle.
    @(negedge clk); reset = 1'b1;
    step(1'b1, 2'b00, 1'b1, 1'b1, 16'h1234, 16'hB00F, 16'hC123);
    step(1'b0, 2'b10, 1'b1, 1'b1, 16'h1234, 16'hB00F, 16'hC123);
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    check_all("async reset", 16'h0000, 16'h0000, 16'h0000);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    // Full schedule from the table.
    foreach (sched[i]) begin
      step(sched[i].sel_k, sched[i].sel_nd, sched[i].ld_d, sched[i].ld_n,
           16'h8000, 16'hC000, 16'h8000);
      check_all($sformatf("sched cycle %0d", i + 1),
                sched[i].exp_n, sched[i].exp_d, sched[i].exp_k);
    end

    // No loads: selects wander, nothing changes.
    for (int i = 0; i < 3; i++) begin
      step(1'(i), 2'(i + 1), 1'b0, 1'b0, 16'(16'h1111 * (i + 1)),
           16'hFFFF, 16'h7777);
      check_all($sformatf("no load %0d", i), 16'h5500, 16'h7F80, 16'h8080);
    end

    // Both loads: regN = regD = 1.0*1.25; regK = 2 - old regD (0x7F80).
    step(1'b1, 2'b00, 1'b1, 1'b1, 16'h0000, 16'hA000, 16'h8000);
    check_all("both loads", 16'hA000, 16'hA000, 16'h8080);

    // Truncation: 0x8001^2 = 0x40010001 -> 0x8002, low bits dropped.
    step(1'b1, 2'b00, 1'b1, 1'b0, 16'h0000, 16'h8001, 16'h8001);
    check("truncation regD", dut.reg_d, 16'h8002);

    // 2 - 0 wraps to 0: load N straight after reset.
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    step(1'b1, 2'b01, 1'b0, 1'b1, 16'h4000, 16'hC000, 16'h8000);
    check_all("wrap 2-0", 16'h4000, 16'h0000, 16'h0000);

    // Randomised steps against the arithmetic model.
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    m_n = 0; m_d = 0; m_k = 0;
    for (int i = 0; i < 200; i++) begin
      logic        sk, ld_d, ld_n;
      logic [1:0]  snd;
      logic [15:0] n_v, d_v, ia_v;
      int unsigned a, b, p, old_d;
      sk   = 1'($urandom);
      snd  = 2'($urandom);
      ld_d = 1'($urandom);
      ld_n = 1'($urandom);
      n_v  = 16'($urandom);
      d_v  = 16'($urandom);
      ia_v = 16'($urandom);
      a = sk ? int'(ia_v) : m_k;
      case (snd)
        2'd0:    b = int'(d_v);
        2'd1:    b = int'(n_v);
        2'd2:    b = m_d;
        default: b = m_n;
      endcase
      p     = q_mul(a, b);
      old_d = m_d;
      if (ld_d) m_d = p;
      if (ld_n) begin
        m_n = p;
        m_k = (131072 - old_d) % 65536;
      end
      step(sk, snd, ld_d, ld_n, n_v, d_v, ia_v);
      check_all($sformatf("random %0d", i), 16'(m_n), 16'(m_d), 16'(m_k));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_datapath
